lcd_line_writer: RTL and testbench

Consumer end of the 2x16 character line-buffer interface. The block takes two 128-bit line images, one ASCII byte per column, from the vending controller. It drives an HD44780-compatible LCD in 8-bit, write-only mode. It runs the power-up init sequence once, then repeatedly rewrites both lines from a per-frame snapshot. It sits between the vending controller's line registers and the LCD pins.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_write_strobe.sv | 91 +++++++++
 rtl/lcd_line_writer.sv | 180 ++++++++++++++++++
 tb/tb_lcd_line_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 line writer: command bytes, FSM encodings
// and small helpers for picking bytes out of a packed 16-column line image.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
  localparam logic [7:0] CMD_LINE1        = 8'h80;
  localparam logic [7:0] CMD_LINE2        = 8'hC0;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2,
    ST_FRAME_END
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } strobe_phase_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_8BIT_2L;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY_INC;
    endcase
  endfunction

  // Column 0 lives in the top byte, so the bit base is (15 - col) * 8 = {~col, 3'b000}.
  function automatic logic [7:0] line_char(input logic [127:0] line, input logic [3:0] col);
    return line[{~col, 3'b000} +: 8];
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One-byte LCD write engine: SETUP (en low), PULSE (en high), HOLD (en low).
// A new start may be taken while idle or in the final HOLD cycle, so ops chain gap-free.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP   = 8,
  parameter int unsigned T_EN_HIGH = 32,
  parameter int unsigned T_CMD     = 5000,
  parameter int unsigned T_CLEAR   = 205000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_is_data,
  input  logic       i_long_hold,
  output logic       o_rs,
  output logic       o_en,
  output logic [7:0] o_data,
  output logic       o_done
);

  localparam int unsigned CNT_MAX = max_of(max_of(T_SETUP, T_EN_HIGH), max_of(T_CMD, T_CLEAR));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  strobe_phase_t    r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rs;
  logic             r_en;
  logic [7:0]       r_data;
  logic             r_long;

  logic w_last;
  logic w_accept;

  assign w_last   = (r_cnt == '0);
  assign o_done   = (r_phase == PH_HOLD) && w_last;
  assign w_accept = i_start && ((r_phase == PH_IDLE) || o_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
      r_long  <= 1'b0;
    end else if (w_accept) begin
      r_phase <= PH_SETUP;
      r_cnt   <= CNT_W'(T_SETUP - 1);
      r_rs    <= i_is_data;
      r_data  <= i_byte;
      r_long  <= i_long_hold;
      r_en    <= 1'b0;
    end else begin
      case (r_phase)
        PH_SETUP: begin
          if (w_last) begin
            r_phase <= PH_PULSE;
            r_en    <= 1'b1;
            r_cnt   <= CNT_W'(T_EN_HIGH - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        PH_PULSE: begin
          if (w_last) begin
            r_phase <= PH_HOLD;
            r_en    <= 1'b0;
            r_cnt   <= r_long ? CNT_W'(T_CLEAR - 1) : CNT_W'(T_CMD - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        PH_HOLD: begin
          if (w_last) begin
            r_phase <= PH_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rs   = r_rs;
  assign o_en   = r_en;
  assign o_data = r_data;

endmodule

// File: rtl/lcd_line_writer.sv
// 2x16 HD44780 writer: power-up wait, 4-command init, then frames of
// 0x80 + 16 chars + 0xC0 + 16 chars taken from a snapshot latched at frame start.
module lcd_line_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = 5000000,
  parameter int unsigned T_SETUP   = 8,
  parameter int unsigned T_EN_HIGH = 32,
  parameter int unsigned T_CMD     = 5000,
  parameter int unsigned T_CLEAR   = 205000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  input  logic         refresh,
  output logic         rs,
  output logic         rw,
  output logic         en,
  output logic [7:0]   data,
  output logic         init_done,
  output logic         busy,
  output logic         frame_done
);

  localparam int unsigned PW_W = $clog2(T_POWERUP + 1);

  lcd_state_t      r_state;
  logic [PW_W-1:0] r_pw_cnt;
  logic [3:0]      r_col;
  logic [127:0]    r_line1;
  logic [127:0]    r_line2;
  logic            r_init_done;
  logic            r_busy;
  logic            r_frame_done;

  logic       w_start;
  logic [7:0] w_byte;
  logic       w_is_data;
  logic       w_long;
  logic       w_done;

  // Next byte is launched on the strobe's final HOLD cycle (or from idle states).
  always_comb begin
    w_start   = 1'b0;
    w_byte    = 8'h00;
    w_is_data = 1'b0;
    case (r_state)
      ST_PWR_WAIT: if (r_pw_cnt == PW_W'(T_POWERUP)) begin
        w_start = 1'b1;
        w_byte  = init_cmd(2'd0);
      end
      ST_INIT: if (w_done && (r_col != 4'd3)) begin
        w_start = 1'b1;
        w_byte  = init_cmd(r_col[1:0] + 2'd1);
      end
      ST_IDLE, ST_FRAME_END: if (refresh) begin
        w_start = 1'b1;
        w_byte  = CMD_LINE1;
      end
      ST_ADDR1: if (w_done) begin
        w_start   = 1'b1;
        w_byte    = line_char(r_line1, 4'd0);
        w_is_data = 1'b1;
      end
      ST_LINE1: if (w_done) begin
        w_start = 1'b1;
        if (r_col == 4'd15) begin
          w_byte = CMD_LINE2;
        end else begin
          w_byte    = line_char(r_line1, r_col + 4'd1);
          w_is_data = 1'b1;
        end
      end
      ST_ADDR2: if (w_done) begin
        w_start   = 1'b1;
        w_byte    = line_char(r_line2, 4'd0);
        w_is_data = 1'b1;
      end
      ST_LINE2: if (w_done && (r_col != 4'd15)) begin
        w_start   = 1'b1;
        w_byte    = line_char(r_line2, r_col + 4'd1);
        w_is_data = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_long = !w_is_data && (w_byte == CMD_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_PWR_WAIT;
      r_pw_cnt     <= '0;
      r_col        <= 4'd0;
      r_line1      <= '0;
      r_line2      <= '0;
      r_init_done  <= 1'b0;
      r_busy       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_PWR_WAIT: begin
          if (r_pw_cnt == PW_W'(T_POWERUP)) begin
            r_state <= ST_INIT;
            r_col   <= 4'd0;
          end else begin
            r_pw_cnt <= r_pw_cnt + PW_W'(1);
          end
        end
        ST_INIT: if (w_done) begin
          if (r_col == 4'd3) begin
            r_state     <= ST_IDLE;
            r_init_done <= 1'b1;
            r_busy      <= 1'b0;
            r_col       <= 4'd0;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        ST_IDLE, ST_FRAME_END: begin
          if (refresh) begin
            r_line1 <= line1;
            r_line2 <= line2;
            r_busy  <= 1'b1;
            r_state <= ST_ADDR1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR1: if (w_done) begin
          r_state <= ST_LINE1;
          r_col   <= 4'd0;
        end
        ST_LINE1: if (w_done) begin
          r_col <= r_col + 4'd1;
          if (r_col == 4'd15) r_state <= ST_ADDR2;
        end
        ST_ADDR2: if (w_done) begin
          r_state <= ST_LINE2;
          r_col   <= 4'd0;
        end
        ST_LINE2: if (w_done) begin
          r_col <= r_col + 4'd1;
          if (r_col == 4'd15) begin
            r_state      <= ST_FRAME_END;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= ST_PWR_WAIT;
      endcase
    end
  end

  lcd_write_strobe #(
    .T_SETUP   (T_SETUP),
    .T_EN_HIGH (T_EN_HIGH),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR)
  ) u_strobe (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_byte      (w_byte),
    .i_is_data   (w_is_data),
    .i_long_hold (w_long),
    .o_rs        (rs),
    .o_en        (en),
    .o_data      (data),
    .o_done      (w_done)
  );

  assign rw         = 1'b0;
  assign init_done  = r_init_done;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Directed bench for lcd_line_writer with a byte scoreboard checked at each en rise.
module tb_lcd_line_writer;

  localparam int TP  = 100;
  localparam int TS  = 2;
  localparam int TE  = 4;
  localparam int TC  = 10;
  localparam int TCL = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] line1 = '0;
  logic [127:0] line2 = '0;
  logic         refresh = 1'b0;
  logic         rs, rw, en, init_done, busy, frame_done;
  logic [7:0]   data;

  lcd_line_writer #(
    .T_POWERUP (TP),
    .T_SETUP   (TS),
    .T_EN_HIGH (TE),
    .T_CMD     (TC),
    .T_CLEAR   (TCL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line1      (line1),
    .line2      (line2),
    .refresh    (refresh),
    .rs         (rs),
    .rw         (rw),
    .en         (en),
    .data       (data),
    .init_done  (init_done),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [8:0] sb[$];

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  logic       prev_en = 1'b0;
  logic       prev_init = 1'b0;
  logic [8:0] last_byte = '0;
  logic [8:0] exp_b;
  int rise_cnt = 0, rises_since_rst = 0, first_rise_cyc = -1;
  int rise_cyc = 0, fall_cyc = 0, clr_gap = -1, init_gap = -1, frame_cnt = 0;

  // Monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      prev_en = 1'b0;
      prev_init = 1'b0;
      rises_since_rst = 0;
    end else begin
      if (en && !prev_en) begin
        rise_cnt++;
        if (rises_since_rst == 0) first_rise_cyc = cyc;
        rises_since_rst++;
        rise_cyc = cyc;
        if (last_byte == 9'h001) clr_gap = cyc - fall_cyc;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_underflow: got byte %h with nothing expected", {rs, data});
        end
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          checks++;
          assert ({rs, data} === exp_b) else begin
            errors++;
            $error("FAIL byte#%0d: got rs/data %h want %h", rise_cnt, {rs, data}, exp_b);
          end
        end
        last_byte = {rs, data};
      end
      if (!en && prev_en) begin
        fall_cyc = cyc;
        checks++;
        assert (cyc - rise_cyc == TE) else begin
          errors++;
          $error("FAIL en_width: got %0d want %0d", cyc - rise_cyc, TE);
        end
      end
      if (init_done && !prev_init) init_gap = cyc - fall_cyc;
      if (frame_done) frame_cnt++;
      prev_en = en;
      prev_init = init_done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push_init();
    sb.push_back(9'h038);
    sb.push_back(9'h00C);
    sb.push_back(9'h001);
    sb.push_back(9'h006);
  endtask

  task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
    sb.push_back(9'h080);
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, l1[127-8*i -: 8]});
    sb.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) sb.push_back({1'b1, l2[127-8*i -: 8]});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rises(input int n);
    int k = 0;
    while (rise_cnt < n && k < 5000) begin step(); k++; end
    chk("wait_rises", rise_cnt >= n, 1);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frame_cnt < n && k < 5000) begin step(); k++; end
    chk("wait_frames", frame_cnt >= n, 1);
  endtask

  task automatic wait_init();
    int k = 0;
    while (init_done !== 1'b1 && k < 2000) begin step(); k++; end
    chk("wait_init", init_done, 1);
  endtask

  int bad;
  int c0;

  initial begin
    // Reset values
    repeat (3) step();
    chk("reset_outputs", {rs, rw, en, data, init_done, busy, frame_done}, {11'b0, 2'b01, 1'b0});
    push_init();
    @(negedge clk);
    rst = 1'b0;

    // Power-up wait: en low, busy high for cycles 0..99
    step();
    bad = 0;
    for (int c = 0; c < TP; c++) begin
      if (en !== 1'b0 || busy !== 1'b1 || cyc != c) bad++;
      step();
    end
    chk("pwr_wait_quiet", bad, 0);
    wait_rises(1);
    chk("first_rise_cycle", first_rise_cyc, 102);

    // Init sequence
    wait_init();
    chk("clear_gap", clr_gap, TCL + TS);
    chk("init_done_after_hold", init_gap, TC);
    chk("idle_busy", busy, 0);
    chk("init_sb_drained", sb.size(), 0);

    // Frame 1 with refresh held high
    line1 = "  ADMIN MODE 1  ";
    line2 = "Price:3$   Num:5";
    push_frame(line1, line2);
    refresh = 1'b1;
    wait_rises(4 + 20);
    line1 = "NOT ENOUGH MONEY";
    push_frame(line1, line2);
    wait_frames(1);
    chk("frame1_ops", rise_cnt, 4 + 34);

    // Drop refresh inside frame 2's LINE1 phase
    wait_rises(4 + 34 + 5);
    refresh = 1'b0;
    wait_frames(2);
    chk("frame2_ops", rise_cnt, 4 + 68);
    step();
    chk("stop_idle_busy_en", {busy, en}, 2'b00);
    chk("stop_idle_rs_data", {rs, data}, {1'b1, 8'h35});
    repeat (20) step();
    chk("stays_idle_rises", rise_cnt, 4 + 68);
    chk("stays_idle_frames", frame_cnt, 2);

    // Restart from IDLE
    push_frame(line1, line2);
    refresh = 1'b1;
    c0 = cyc;
    step();
    refresh = 1'b0;
    wait_rises(4 + 68 + 1);
    chk("restart_setup", rise_cyc - c0, 1 + TS);

    // Reset while en is high mid-frame
    wait_rises(4 + 68 + 9);
    chk("pre_reset_en", en, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_en", en, 0);
    chk("async_reset_flags", {init_done, busy, frame_done}, 3'b010);
    sb.delete();
    push_init();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_init();
    chk("rerun_first_rise", first_rise_cyc, 102);
    chk("rerun_clear_gap", clr_gap, TCL + TS);
    chk("rerun_sb_drained", sb.size(), 0);
    chk("aborted_frame_no_pulse", frame_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
